// File: rtl/csr_regblock_if.sv
// rtl/csr_regblock_if.sv - internal register bus between the APB bridge and csr_regblock
interface csr_regblock_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32
);
   logic                    bus_req;
   logic                    bus_req_is_wr;
   logic [ADDR_WIDTH-1:0]   bus_addr;
   logic [DATA_WIDTH-1:0]   bus_wr_data;
   logic [DATA_WIDTH/8-1:0] bus_wr_biten;
   logic                    bus_ready;
   logic [DATA_WIDTH-1:0]   bus_rd_data;
   logic                    bus_err;

   modport master (
      output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
      input  bus_ready, bus_rd_data, bus_err
   );

   modport slave (
      input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
      output bus_ready, bus_rd_data, bus_err
   );
endinterface

// File: rtl/csr_regblock.sv
// rtl/csr_regblock.sv - CTRL/STATUS/IRQ_MASK/SCRATCH/COUNTER/COMPARE register block
// Ready is combinational after WAIT_STATES cycles of bus_req; writes commit on the ready edge.
module csr_regblock #(
   parameter int ADDR_WIDTH  = 3,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   csr_regblock_if.slave bus,
   input  logic [5:0]    hw_event_i,
   output logic          cnt_en_o,
   output logic          irq_o
);
   localparam int                    NB       = DATA_WIDTH / 8;
   localparam logic [3:0]            WS       = 4'(WAIT_STATES);
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

   logic [3:0]            wait_q, wait_d;
   logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
   logic [DATA_WIDTH-1:0] counter_q, counter_d;
   logic [DATA_WIDTH-1:0] compare_q, compare_d;
   logic [7:0]            status_q, status_d;
   logic [7:0]            status_set, status_clr;
   logic                  irq_q, irq_d;

   logic                  ready, mapped, wr_en, counting;
   logic [31:0]           addr_w;
   logic [5:0]            wr_sel;
   logic [DATA_WIDTH-1:0] bmask, rd_data;

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                   input logic [DATA_WIDTH-1:0] new_v,
                                                   input logic [DATA_WIDTH-1:0] m);
      return (old_v & ~m) | (new_v & m);
   endfunction

   assign addr_w = 32'(bus.bus_addr);
   assign mapped = addr_w < 32'd6;
   assign ready  = bus.bus_req & (wait_q == WS);
   assign wr_en  = ready & bus.bus_req_is_wr & mapped;

   always_comb begin
      wr_sel = '0;
      for (int k = 0; k < 6; k++) begin
         wr_sel[k] = wr_en & (addr_w == 32'(k));
      end
      bmask = '0;
      for (int b = 0; b < NB; b++) begin
         bmask[b*8 +: 8] = {8{bus.bus_wr_biten[b]}};
      end
   end

   // A bus write to COUNTER takes the cycle: no increment, no wrap/match on that edge.
   assign counting = ctrl_q[0] & ~wr_sel[4];

   always_comb begin
      wait_d     = (!bus.bus_req || ready) ? 4'd0 : wait_q + 4'd1;
      ctrl_d     = wr_sel[0] ? merge(ctrl_q, bus.bus_wr_data, bmask) : ctrl_q;
      mask_d     = wr_sel[2] ? merge(mask_q, bus.bus_wr_data, bmask) : mask_q;
      scratch_d  = wr_sel[3] ? merge(scratch_q, bus.bus_wr_data, bmask) : scratch_q;
      compare_d  = wr_sel[5] ? merge(compare_q, bus.bus_wr_data, bmask) : compare_q;
      counter_d  = counter_q;
      if (wr_sel[4]) begin
         counter_d = merge(counter_q, bus.bus_wr_data, bmask);
      end else if (counting) begin
         counter_d = counter_q + DATA_WIDTH'(1);
      end
      status_set = {counting & (counter_q == compare_q),
                    counting & (counter_q == ALL_ONES),
                    hw_event_i};
      status_clr = (wr_sel[1] & bus.bus_wr_biten[0]) ? bus.bus_wr_data[7:0] : 8'd0;
      // Hardware set wins over a same-cycle W1C on the same bit.
      status_d   = (status_q & ~status_clr) | status_set;
      irq_d      = ctrl_q[1] & |(status_q & mask_q[7:0]);
   end

   always_comb begin
      rd_data = '0;
      if (ready && !bus.bus_req_is_wr) begin
         case (addr_w)
            32'd0:   rd_data = ctrl_q;
            32'd1:   rd_data = {{(DATA_WIDTH-8){1'b0}}, status_q};
            32'd2:   rd_data = mask_q;
            32'd3:   rd_data = scratch_q;
            32'd4:   rd_data = counter_q;
            32'd5:   rd_data = compare_q;
            default: rd_data = '0;
         endcase
      end
   end

   assign bus.bus_ready   = ready;
   assign bus.bus_rd_data = rd_data;
   assign bus.bus_err     = ready & ~mapped;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_q    <= '0;
         ctrl_q    <= '0;
         status_q  <= '0;
         mask_q    <= '0;
         scratch_q <= '0;
         counter_q <= '0;
         compare_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         ctrl_q    <= ctrl_d;
         status_q  <= status_d;
         mask_q    <= mask_d;
         scratch_q <= scratch_d;
         counter_q <= counter_d;
         compare_q <= compare_d;
         irq_q     <= irq_d;
      end
   end

   assign cnt_en_o = ctrl_q[0];
   assign irq_o    = irq_q;
endmodule

// File: tb/tb_csr_regblock.sv
// tb/tb_csr_regblock.sv - randomized and directed bench for csr_regblock against a register-map model
module tb_csr_regblock;
   localparam int WS = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, wr;
   logic [2:0]  addr;
   logic [31:0] wd;
   logic [3:0]  be;
   logic [5:0]  ev;
   logic        req0;
   logic [2:0]  addr0;
   logic        irq3, cnt3, irq0, cnt0;

   always #5 clk = ~clk;

   csr_regblock_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) b3 ();
   csr_regblock_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) b0 ();

   assign b3.bus_req       = req;
   assign b3.bus_req_is_wr = wr;
   assign b3.bus_addr      = addr;
   assign b3.bus_wr_data   = wd;
   assign b3.bus_wr_biten  = be;
   assign b0.bus_req       = req0;
   assign b0.bus_req_is_wr = 1'b0;
   assign b0.bus_addr      = addr0;
   assign b0.bus_wr_data   = 32'd0;
   assign b0.bus_wr_biten  = 4'd0;

   csr_regblock #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .WAIT_STATES(WS)) u_dut (
      .clk_i(clk), .rst_i(rst), .bus(b3), .hw_event_i(ev), .cnt_en_o(cnt3), .irq_o(irq3));

   csr_regblock #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .bus(b0), .hw_event_i(6'd0), .cnt_en_o(cnt0), .irq_o(irq0));

   int checks = 0;
   int failures = 0;

   // Register map model: index = word address, STATUS kept as its 8 live bits.
   logic [31:0] m_reg [6];
   logic        m_irq;
   int          m_wait;

   logic [31:0] r_data;
   logic        r_err;
   int          r_lat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      logic        rdy, commit;
      logic [31:0] bm, set, clr;
      int          a;
      a   = int'(addr);
      rdy = req && (m_wait == WS);
      if (rst) begin
         foreach (m_reg[i]) m_reg[i] = 32'd0;
         m_irq  = 1'b0;
         m_wait = 0;
         return;
      end
      commit = rdy && wr && (a < 6);
      bm = 32'd0;
      for (int i = 0; i < 4; i++) if (be[i]) bm[i*8 +: 8] = 8'hFF;
      m_irq = m_reg[0][1] && ((m_reg[1] & m_reg[2] & 32'hFF) != 0);
      set = {26'd0, ev};
      if (m_reg[0][0] && !(commit && a == 4)) begin
         if (m_reg[4] == m_reg[5]) set = set | 32'h80;
         if (m_reg[4] == 32'hFFFF_FFFF) set = set | 32'h40;
         m_reg[4] = m_reg[4] + 32'd1;
      end
      clr = (commit && a == 1 && be[0]) ? (wd & 32'hFF) : 32'd0;
      m_reg[1] = (m_reg[1] & ~clr) | set;
      if (commit && a != 1) m_reg[a] = (m_reg[a] & ~bm) | (wd & bm);
      m_wait = (!req || rdy) ? 0 : m_wait + 1;
   endtask

   task automatic cmp();
      logic        er;
      logic [31:0] erd;
      er  = req && (m_wait == WS);
      erd = (er && !wr && addr < 3'd6) ? m_reg[addr] : 32'd0;
      check("ready", 32'(b3.bus_ready), 32'(er));
      check("err", 32'(b3.bus_err), 32'(er && addr >= 3'd6));
      check("rd_data", b3.bus_rd_data, erd);
      check("irq", 32'(irq3), 32'(m_irq));
      check("cnt_en", 32'(cnt3), 32'(m_reg[0][0]));
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      ev = 6'd0;
   endtask

   task automatic tick();
      #1;
      cmp();
      edge_step();
   endtask

   task automatic wait_ready(input logic [5:0] ev_rdy);
      logic got;
      r_lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (n == WS) ev = ev_rdy;
         #1;
         cmp();
         got    = b3.bus_ready;
         r_data = b3.bus_rd_data;
         r_err  = b3.bus_err;
         edge_step();
         if (got) begin
            r_lat = n;
            break;
         end
      end
      if (r_lat < 0) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic access(input logic w, input int a, input logic [31:0] d,
                         input logic [3:0] b, input logic [5:0] ev_rdy);
      req = 1'b1; wr = w; addr = 3'(a); wd = d; be = b;
      wait_ready(ev_rdy);
      req = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 3'd0; wd = 32'd0; be = 4'd0; ev = 6'd0;
      req0 = 1'b0; addr0 = 3'd0;
      foreach (m_reg[i]) m_reg[i] = 32'd0;
      m_irq = 1'b0; m_wait = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      #1;
      check("rst_ready", 32'(b3.bus_ready), 32'd0);
      check("rst_irq", 32'(irq3), 32'd0);
      check("rst_ready0", 32'(b0.bus_ready), 32'd0);
      @(negedge clk);
      for (int a = 0; a < 6; a++) begin
         req0 = 1'b1; addr0 = 3'(a);
         #1;
         check("ws0_ready", 32'(b0.bus_ready), 32'd1);
         check("ws0_data", b0.bus_rd_data, 32'd0);
         check("ws0_err", 32'(b0.bus_err), 32'd0);
         tick();
         req0 = 1'b0;
         tick();
      end

      access(1'b1, 3, 32'hDEAD_BEEF, 4'b0101, 6'd0);
      check("wr_lat", 32'(r_lat), 32'd3);
      access(1'b0, 3, 32'd0, 4'd0, 6'd0);
      check("rd_lat", 32'(r_lat), 32'd3);
      check("scratch_be", r_data, 32'h00AD_00EF);

      ev = 6'h05;
      tick();
      access(1'b1, 2, 32'h1, 4'hF, 6'd0);
      access(1'b1, 0, 32'h2, 4'hF, 6'd0);
      tick();
      check("irq_on", 32'(irq3), 32'd1);
      access(1'b1, 1, 32'h1, 4'hF, 6'd0);
      check("irq_off", 32'(irq3), 32'd0);
      access(1'b0, 1, 32'd0, 4'd0, 6'd0);
      check("status_w1c", r_data, 32'h04);
      access(1'b1, 1, 32'h4, 4'h1, 6'h04);
      access(1'b0, 1, 32'd0, 4'd0, 6'd0);
      check("set_beats_clr", r_data, 32'h04);

      access(1'b1, 4, 32'hFFFF_FFFE, 4'hF, 6'd0);
      access(1'b1, 0, 32'h1, 4'hF, 6'd0);
      access(1'b0, 4, 32'd0, 4'd0, 6'd0);
      check("counter_wrap", r_data, 32'd2);
      access(1'b0, 1, 32'd0, 4'd0, 6'd0);
      check("status_wrap", 32'(r_data[6]), 32'd1);

      access(1'b1, 0, 32'h0, 4'hF, 6'd0);
      access(1'b1, 1, 32'hFF, 4'h1, 6'd0);
      access(1'b0, 1, 32'd0, 4'd0, 6'd0);
      check("status_clr_all", r_data, 32'd0);
      access(1'b1, 5, 32'h10, 4'hF, 6'd0);
      access(1'b1, 4, 32'h0, 4'hF, 6'd0);
      access(1'b1, 0, 32'h1, 4'hF, 6'd0);
      access(1'b0, 1, 32'd0, 4'd0, 6'd0);
      check("no_match_yet", r_data, 32'd0);
      repeat (20) tick();
      access(1'b0, 1, 32'd0, 4'd0, 6'd0);
      check("match", r_data, 32'h80);
      access(1'b1, 0, 32'h0, 4'hF, 6'd0);

      access(1'b1, 6, 32'hFFFF_FFFF, 4'hF, 6'd0);
      check("unmapped_wr_err", 32'(r_err), 32'd1);
      access(1'b0, 6, 32'd0, 4'd0, 6'd0);
      check("unmapped_rd_err", 32'(r_err), 32'd1);
      check("unmapped_rd_data", r_data, 32'd0);
      access(1'b0, 3, 32'd0, 4'd0, 6'd0);
      check("unmapped_no_change", r_data, 32'h00AD_00EF);

      access(1'b1, 0, 32'h3, 4'hF, 6'd0);
      req = 1'b1; wr = 1'b1; addr = 3'd3; wd = 32'h1234_5678; be = 4'hF;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(6'd0);
      check("rst_mid_lat", 32'(r_lat), 32'd3);
      req = 1'b0;
      tick();
      access(1'b0, 3, 32'd0, 4'd0, 6'd0);
      check("rst_mid_commit", r_data, 32'h1234_5678);
      access(1'b0, 0, 32'd0, 4'd0, 6'd0);
      check("rst_ctrl", r_data, 32'd0);
      access(1'b0, 2, 32'd0, 4'd0, 6'd0);
      check("rst_mask", r_data, 32'd0);

      repeat (250) begin
         repeat ($urandom_range(0, 3)) begin
            ev = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            tick();
         end
         access(1'($urandom), int'($urandom_range(0, 7)), $urandom, 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
